// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller for the 5-stage MIPS pipe: load-use and branch interlocks, redirect flush, memory-wait freeze, interrupt entry, perf counters.
// Latency: control outputs are combinational in the current cycle; epc, in_handler and counters update at the next rising edge.
// Backpressure: a memory access without mem_ready freezes the whole pipe until mem_ready; freeze overrides every other control output.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ID inputs             valid_id, rs_id/rt_id with use flags, branch_id, jr_id, redirect_id, eret_id, pc_id
//   EX/MEM inputs         wa_ex, regwr_ex, memrd_ex, wa_mem, memrd_mem, mem_req, mem_ready
//   irq                   level interrupt request
//   stall/bubble_ex/flush_id/freeze/irq_take   pipeline control (combinational)
//   epc, in_handler       interrupt return PC and handler mask (registered)
//   stall_cnt, flush_cnt  saturating performance counters (registered)

module pipe_hazard_ctrl #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic [AW-1:0]    rs_id,
  input  logic [AW-1:0]    rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             branch_id,
  input  logic             jr_id,
  input  logic             redirect_id,
  input  logic             eret_id,
  input  logic [DW-1:0]    pc_id,
  input  logic [AW-1:0]    wa_ex,
  input  logic             regwr_ex,
  input  logic             memrd_ex,
  input  logic [AW-1:0]    wa_mem,
  input  logic             memrd_mem,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             irq,
  output logic             stall,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             freeze,
  output logic             irq_take,
  output logic [DW-1:0]    epc,
  output logic             in_handler,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t nextState;
  logic   irqPend;

  // Register $0 never creates a dependency.
  logic rsHitEx, rtHitEx, rsHitMem, rtHitMem;
  logic depEx, depMem, loadUse, branchDep, haz;
  logic eretClear;

  assign rsHitEx  = use_rs_id && (rs_id != '0) && (rs_id == wa_ex);
  assign rtHitEx  = use_rt_id && (rt_id != '0) && (rt_id == wa_ex);
  assign rsHitMem = use_rs_id && (rs_id != '0) && (rs_id == wa_mem);
  assign rtHitMem = use_rt_id && (rt_id != '0) && (rt_id == wa_mem);

  assign depEx     = regwr_ex  && (rsHitEx  || rtHitEx);
  assign depMem    = memrd_mem && (rsHitMem || rtHitMem);
  assign loadUse   = memrd_ex && depEx;
  // ID-stage compares cannot use the EX->ID forward of a load, so a load
  // producer holds here for a second cycle via the MEM-stage term.
  assign branchDep = (branch_id || jr_id) && (depEx || depMem);
  assign haz       = valid_id && (loadUse || branchDep);

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    irq_take  = 1'b0;
    eretClear = 1'b0;
    if (!reset) begin
      case (state)
        S_RUN: begin
          if (mem_req && !mem_ready) begin
            nextState = S_WAIT;
            freeze    = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_ready) nextState = S_RUN;
          else           freeze    = 1'b1;
        end
        default: nextState = S_RUN;
      endcase

      if (!freeze) begin
        if (irqPend && !in_handler && valid_id && !haz) begin
          // The ID instruction is killed; it re-executes after eret.
          irq_take  = 1'b1;
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (haz) begin
          stall     = 1'b1;
          bubble_ex = 1'b1;
        end else if (redirect_id && valid_id) begin
          flush_id  = 1'b1;
        end
        eretClear = eret_id && valid_id && !haz;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RUN;
      irqPend    <= 1'b0;
      in_handler <= 1'b0;
      epc        <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state <= nextState;
      if (irq_take) begin
        irqPend    <= 1'b0;
        in_handler <= 1'b1;
        epc        <= pc_id;
      end else begin
        irqPend <= irq;
        if (eretClear) in_handler <= 1'b0;
      end
      if ((stall || freeze) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CntOne;
      if (flush_id && (flush_cnt != '1))          flush_cnt <= flush_cnt + CntOne;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by randomized traffic against a reference model.
// Latency: model predicts combinational outputs before each edge and registered outputs after it.
// Backpressure: memory waits are modelled as a simple "access outstanding" flag.

module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;   // small counter width so saturation is reachable

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_id, use_rs_id, use_rt_id, branch_id, jr_id, redirect_id, eret_id;
  logic [AW-1:0] rs_id, rt_id, wa_ex, wa_mem;
  logic [DW-1:0] pc_id;
  logic          regwr_ex, memrd_ex, memrd_mem, mem_req, mem_ready, irq;
  logic          stall, bubble_ex, flush_id, freeze, irq_take, in_handler;
  logic [DW-1:0] epc;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            mWait, mPend, mInH;
  logic [DW-1:0] mEpc;
  int            mStall, mFlush;
  // Model predictions for the current cycle
  bit eStall, eBubble, eFlush, eFreeze, eTake, eHaz;
  // DUT combinational outputs sampled just before the edge
  logic sStall, sBubble, sFlush, sFreeze, sTake;

  pipe_hazard_ctrl #(.AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .branch_id(branch_id), .jr_id(jr_id),
    .redirect_id(redirect_id), .eret_id(eret_id), .pc_id(pc_id), .wa_ex(wa_ex),
    .regwr_ex(regwr_ex), .memrd_ex(memrd_ex), .wa_mem(wa_mem), .memrd_mem(memrd_mem),
    .mem_req(mem_req), .mem_ready(mem_ready), .irq(irq), .stall(stall),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .freeze(freeze), .irq_take(irq_take),
    .epc(epc), .in_handler(in_handler), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit readsReg(input logic [AW-1:0] r);
    return (r != 0) && ((use_rs_id && rs_id == r) || (use_rt_id && rt_id == r));
  endfunction

  task automatic predict();
    bit depEx, depMem;
    {eStall, eBubble, eFlush, eFreeze, eTake, eHaz} = '0;
    if (!reset) begin
      depEx   = regwr_ex && readsReg(wa_ex);
      depMem  = memrd_mem && readsReg(wa_mem);
      eHaz    = valid_id && ((memrd_ex && depEx) || ((branch_id || jr_id) && (depEx || depMem)));
      // Pipe is frozen while a memory access is outstanding and not yet done.
      eFreeze = !mem_ready && (mWait || mem_req);
      if (!eFreeze) begin
        if (mPend && !mInH && valid_id && !eHaz) begin
          eTake = 1; eFlush = 1; eBubble = 1;
        end else if (eHaz) begin
          eStall = 1; eBubble = 1;
        end else if (redirect_id && valid_id) begin
          eFlush = 1;
        end
      end
    end
  endtask

  task automatic advanceModel();
    int cmax;
    cmax = (1 << CW) - 1;
    if (reset) begin
      mWait = 0; mPend = 0; mInH = 0; mEpc = '0; mStall = 0; mFlush = 0;
    end else begin
      if (eTake) begin
        mPend = 0; mInH = 1; mEpc = pc_id;
      end else begin
        mPend = irq;
        if (eret_id && valid_id && !eFreeze && !eHaz) mInH = 0;
      end
      if (mWait) mWait = !mem_ready;
      else       mWait = mem_req && !mem_ready;
      if ((eStall || eFreeze) && mStall < cmax) mStall++;
      if (eFlush && mFlush < cmax) mFlush++;
    end
  endtask

  // One clock: inputs must already be driven (away from the edge).
  task automatic cycle();
    #1;
    predict();
    sStall = stall; sBubble = bubble_ex; sFlush = flush_id; sFreeze = freeze; sTake = irq_take;
    checkVal("stall",     32'(sStall),  32'(eStall));
    checkVal("bubble_ex", 32'(sBubble), 32'(eBubble));
    checkVal("flush_id",  32'(sFlush),  32'(eFlush));
    checkVal("freeze",    32'(sFreeze), 32'(eFreeze));
    checkVal("irq_take",  32'(sTake),   32'(eTake));
    @(posedge clk);
    advanceModel();
    #1;
    checkVal("epc",        epc,             mEpc);
    checkVal("in_handler", 32'(in_handler), 32'(mInH));
    checkVal("stall_cnt",  32'(stall_cnt),  32'(mStall));
    checkVal("flush_cnt",  32'(flush_cnt),  32'(mFlush));
  endtask

  task automatic idle();
    reset = 0; valid_id = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
    branch_id = 0; jr_id = 0; redirect_id = 0; eret_id = 0; pc_id = '0;
    wa_ex = 0; regwr_ex = 0; memrd_ex = 0; wa_mem = 0; memrd_mem = 0;
    mem_req = 0; mem_ready = 0; irq = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1;
    cycle();
    checkVal("rst_stall",  32'(sStall),  0);
    checkVal("rst_freeze", 32'(sFreeze), 0);
    reset = 0;
  endtask

  initial begin
    idle();
    @(posedge clk); #1;

    // Reset forces everything low even with hazardous/pending inputs.
    idle();
    reset = 1; valid_id = 1; use_rs_id = 1; rs_id = 8; wa_ex = 8; regwr_ex = 1; memrd_ex = 1;
    mem_req = 1; irq = 1;
    cycle();
    checkVal("rst_comb_stall",  32'(sStall),  0);
    checkVal("rst_comb_freeze", 32'(sFreeze), 0);
    checkVal("rst_epc",         epc,          0);
    checkVal("rst_cnt",         32'(stall_cnt), 0);
    doReset();

    // Load to $0 is never a dependency.
    valid_id = 1; use_rs_id = 1; rs_id = 0; wa_ex = 0; regwr_ex = 1; memrd_ex = 1;
    cycle();
    checkVal("lu0_stall", 32'(sStall), 0);
    checkVal("lu0_cnt",   32'(stall_cnt), 0);

    // lw $8 in EX, add reads $8: one stall cycle.
    idle(); valid_id = 1; use_rs_id = 1; rs_id = 8; wa_ex = 8; regwr_ex = 1; memrd_ex = 1;
    cycle();
    checkVal("lu_stall",  32'(sStall),  1);
    checkVal("lu_bubble", 32'(sBubble), 1);
    regwr_ex = 0; memrd_ex = 0; wa_ex = 0; memrd_mem = 1; wa_mem = 8;
    cycle();
    checkVal("lu_release", 32'(sStall), 0);
    checkVal("lu_cnt",     32'(stall_cnt), 1);

    // lw $9 then beq on $9: two stall cycles, then the redirect flushes.
    idle(); valid_id = 1; branch_id = 1; use_rs_id = 1; rs_id = 9; redirect_id = 1;
    wa_ex = 9; regwr_ex = 1; memrd_ex = 1;
    cycle();
    checkVal("br_stall1", 32'(sStall), 1);
    checkVal("br_noflush", 32'(sFlush), 0);
    regwr_ex = 0; memrd_ex = 0; wa_ex = 0; memrd_mem = 1; wa_mem = 9;
    cycle();
    checkVal("br_stall2", 32'(sStall), 1);
    memrd_mem = 0; wa_mem = 0;
    cycle();
    checkVal("br_go",     32'(sStall), 0);
    checkVal("br_flush",  32'(sFlush), 1);
    checkVal("br_fcnt",   32'(flush_cnt), 1);
    checkVal("br_scnt",   32'(stall_cnt), 3);

    // Three-cycle memory wait.
    doReset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkVal("frz_on", 32'(sFreeze), 1);
      mem_req = 0;
    end
    mem_ready = 1;
    cycle();
    checkVal("frz_off", 32'(sFreeze), 0);
    checkVal("frz_cnt", 32'(stall_cnt), 3);
    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkVal("frz_single", 32'(sFreeze), 0);
    end

    // Interrupt entry, mask, eret and re-entry.
    doReset();
    valid_id = 1; pc_id = 32'h0040_0010; irq = 1;
    cycle();
    checkVal("irq_lat0", 32'(sTake), 0);
    cycle();
    checkVal("irq_take",  32'(sTake), 1);
    checkVal("irq_flush", 32'(sFlush), 1);
    checkVal("irq_epc",   epc, 32'h0040_0010);
    checkVal("irq_inh",   32'(in_handler), 1);
    irq = 0; pc_id = 32'h8000_0180;
    cycle();
    irq = 1;
    cycle();
    checkVal("irq_masked1", 32'(sTake), 0);
    cycle();
    checkVal("irq_masked2", 32'(sTake), 0);
    eret_id = 1; pc_id = 32'h8000_01a0;
    cycle();
    checkVal("eret_notake", 32'(sTake), 0);
    checkVal("eret_inh",    32'(in_handler), 0);
    eret_id = 0; pc_id = 32'h0040_0020;
    cycle();
    checkVal("irq_retake", 32'(sTake), 1);
    checkVal("irq_epc2",   epc, 32'h0040_0020);

    // Pending interrupt during freeze, then reset.
    doReset();
    valid_id = 1; pc_id = 32'h0040_0030; mem_req = 1; irq = 1;
    cycle();
    cycle();
    checkVal("frzirq_notake", 32'(sTake), 0);
    reset = 1;
    cycle();
    checkVal("frzirq_rst_take", 32'(sTake), 0);
    idle(); valid_id = 1; pc_id = 32'h0040_0040;
    cycle();
    checkVal("post_rst_take",   32'(sTake), 0);
    checkVal("post_rst_freeze", 32'(sFreeze), 0);
    checkVal("post_rst_epc",    epc, 0);
    checkVal("post_rst_cnt",    32'(stall_cnt), 0);
    checkVal("post_rst_fcnt",   32'(flush_cnt), 0);

    // Randomized traffic with occasional resets; counters saturate between resets.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      valid_id    = ($urandom_range(0, 3) != 0);
      rs_id       = AW'($urandom_range(0, 3));
      rt_id       = AW'($urandom_range(0, 3));
      use_rs_id   = 1'($urandom);
      use_rt_id   = 1'($urandom);
      branch_id   = ($urandom_range(0, 3) == 0);
      jr_id       = ($urandom_range(0, 7) == 0);
      redirect_id = ($urandom_range(0, 3) == 0);
      eret_id     = ($urandom_range(0, 7) == 0);
      pc_id       = $urandom;
      wa_ex       = AW'($urandom_range(0, 3));
      regwr_ex    = 1'($urandom);
      memrd_ex    = 1'($urandom);
      wa_mem      = AW'($urandom_range(0, 3));
      memrd_mem   = 1'($urandom);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = 1'($urandom);
      irq         = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
